dut_line_buffer: RTL and testbench
==================================

# dut_line_buffer

Two-line buffer directly downstream of the scan controller. It takes the raster pixel stream qualified by `pixel_valid` and the line-start pulse `start_x`. For each incoming pixel it presents a registered vertical 3-pixel column: the pixel at the same x in line n-2, in line n-1, and in the current line n. The next stage is the 3x3 window/filter.

## Interface
Parameters:
- `DATA_W`, 8: pixel width in bits.
- `MAX_LINE`, 64: maximum pixels per line; sets the depth of each line memory.
- `ADDR_W`, `$clog2(MAX_LINE)`: column address width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `flush`, in, 1: synchronous clear of the fill state; memory contents are not cleared.
- `line_start`, in, 1: pulse that marks the first pixel of a line; only sampled when `pix_valid`=1.
- `pix_valid`, in, 1: input pixel qualifier.
- `pix_data`, in, `DATA_W`: input pixel.
- `win_top`, out, `DATA_W`: pixel from line n-2.
- `win_mid`, out, `DATA_W`: pixel from line n-1.
- `win_bot`, out, `DATA_W`: pixel from line n (the current pixel).
- `win_valid`, out, 1: the column outputs are valid.
- `win_col`, out, `ADDR_W`: x coordinate of the presented column.
- `lines_filled`, out, 2: completed lines stored, saturating at 2.
- `err`, out, 1: sticky error flag (overflow or length mismatch).

## Operation
- **Storage:** two line memories, A and B, with bank select `sel`.
  - `mem[sel]` holds line n-1; `mem[~sel]` holds line n-2.
- **Per accepted pixel** (`pix_valid`=1) at column `col`:
  - read `mem[~sel][col]` to top and `mem[sel][col]` to mid; bot = `pix_data`;
  - write `pix_data` to `mem[~sel][col]` (read-before-write);
  - `col` increments.
- **`line_start`=1 with `pix_valid`=1:**
  - `col`=0 for this pixel.
  - If a line was already in progress: toggle `sel` before the access, capture `line_len` = previous `col` (the first time only), and increment `lines_filled` (saturating at 2).
- **`win_valid`:** asserted for a pixel only when `lines_filled`=2 at the time of its access.
- **Overflow:** a pixel with `col`=`MAX_LINE` and no `line_start` is dropped; `err` is set; `col` holds.
- **Length check:** once `line_len` is captured, a `line_start` arriving when `col`≠`line_len` sets `err`; the line is still accepted.
- **Pixel without a start:** `pix_valid` without a prior `line_start` after reset/flush is ignored (no write, no output).
- **`flush`:** `lines_filled`=0, the in-progress flag clears, `line_len` is invalidated, `err` is kept. `flush` wins over a simultaneous pixel, which is dropped.
- **Reset:** clears everything including `err` and `sel`=0.

## Timing
- Latency: `win_*` and `win_col` are registered, one cycle after the accepting `pix_valid` edge. `win_valid` is a single-cycle pulse per pixel.
- Reset values: `win_top`/`win_mid`/`win_bot`=0, `win_valid`=0, `win_col`=0, `lines_filled`=0, `err`=0.
- Back-to-back pixels every cycle are supported; gaps in `pix_valid` produce gaps in `win_valid`.
- Reset asserted mid-line: outputs are at reset values the next cycle; the first post-reset `line_start` restarts the fill.
- Memory read and write to the same address in the same cycle return the old data.

## Configuration
- **`DUT_LINE_BUFFER_EDGE_REPLICATE_EN` defined:**
  - `win_valid` is asserted from the first line.
  - Missing rows are replicated from the nearest available row:
    - `lines_filled`=0 gives top=mid=bot=`pix_data`;
    - `lines_filled`=1 gives top=mid=line n-1.
- **Not defined:** `win_valid` is only asserted once `lines_filled`=2; the first two lines produce no output.

## Structure
- Shared package `dut_image_pkg`:
  - `pixel_t` (`logic [DATA_W-1:0]`);
  - default `DATA_W` and `MAX_LINE` constants;
  - `win_col_t` typedef.
- One sub-module, `dut_line_ram`: single-port, synchronous, read-before-write, depth `MAX_LINE`, instantiated twice.
- The top level contains the column counter, bank select, fill/length tracking, error logic and the output register.

## Test plan
- **Fill:** 3 lines of 4 pixels, values 0x10–0x13, 0x20–0x23, 0x30–0x33, each line starting with `line_start`.
  - `win_valid` only during line 3.
  - Column 2 gives top=0x12, mid=0x22, bot=0x32, `win_col`=2, one cycle after the input.
- **Rotation:** a 4th line 0x40–0x43.
  - Gives top=0x2x, mid=0x3x, bot=0x4x.
  - `lines_filled` stays 2.
- **Overflow:** `MAX_LINE`=64 and 66 pixels after one `line_start`.
  - `err`=1 at pixel 65; pixels 65–66 dropped; `col` stays 64.
- **Length mismatch:** lines of 4 then 3 pixels.
  - `err`=1 at the third `line_start`; data still passes.
- **Flush/reset mid-line:** `flush` during line 3.
  - `win_valid` drops.
  - The next two lines give no output (without the macro) or replicated output (with the macro: line 1 pixel 0x55 gives top=mid=bot=0x55).
- **Gapped input:** `pix_valid` asserted 1 cycle out of 3.
  - `win_valid` pulses exactly 1 cycle after each accepted pixel, with no duplicates.

Source files
------------

// File: rtl/dut_image_pkg.sv
// ---------------------------------------------------------------------------
// dut_image_pkg
// Shared image-pipeline types and default sizing for the line buffer and
// the line RAM.
//   pixel_t      : one pixel at the default width
//   win_col_t    : column index at the default line length
//   DATA_W_DEF   : default pixel width in bits
//   MAX_LINE_DEF : default maximum pixels per line
//   fill_inc()   : line-fill counter increment, saturating at 2
// ---------------------------------------------------------------------------
package dut_image_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int MAX_LINE_DEF = 64;
    localparam int ADDR_W_DEF   = $clog2(MAX_LINE_DEF);

    typedef logic [DATA_W_DEF-1:0] pixel_t;
    typedef logic [ADDR_W_DEF-1:0] win_col_t;

    function automatic logic [1:0] fill_inc(input logic [1:0] lf);
        return (lf == 2'd2) ? 2'd2 : lf + 2'd1;
    endfunction

endpackage

// File: rtl/dut_line_ram.sv
// ---------------------------------------------------------------------------
// dut_line_ram
// Single-port synchronous line memory, read-before-write: a read and write
// to the same address in one cycle returns the old contents.
//   clk   : clock
//   rst   : synchronous active-high reset (read register only)
//   en    : access enable (read, and write when we=1)
//   we    : write enable
//   addr  : column address
//   wdata : write data
//   rdata : registered read data
// ---------------------------------------------------------------------------
module dut_line_ram
    import dut_image_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = MAX_LINE_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto RAM primitives;
    // only the read register below is reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // NOTE: non-blocking assignment in both processes is what gives
    // read-before-write: the read samples mem before the write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dut_line_buffer.sv
// ---------------------------------------------------------------------------
// dut_line_buffer
// Two-line buffer: for each accepted pixel presents the registered vertical
// column (line n-2, line n-1, line n) at the same x, one cycle later.
// Optional macro DUT_LINE_BUFFER_EDGE_REPLICATE_EN: output from the first
// line, replicating missing rows from the nearest available row.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : clear fill state (memory and err kept)
//   line_start    : first pixel of a line (qualified by pix_valid)
//   pix_valid     : input pixel qualifier
//   pix_data      : input pixel
//   win_top/mid/bot : column pixels from lines n-2 / n-1 / n
//   win_valid     : column valid (one pulse per pixel)
//   win_col       : x of the presented column
//   lines_filled  : completed lines stored, saturating at 2
//   err           : sticky overflow / line-length mismatch flag
// ---------------------------------------------------------------------------
module dut_line_buffer
    import dut_image_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_LINE = MAX_LINE_DEF,
    parameter int ADDR_W   = $clog2(MAX_LINE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              line_start,
    input  logic              pix_valid,
    input  logic [DATA_W-1:0] pix_data,
    output logic [DATA_W-1:0] win_top,
    output logic [DATA_W-1:0] win_mid,
    output logic [DATA_W-1:0] win_bot,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_col,
    output logic [1:0]        lines_filled,
    output logic              err
);

    // Column counter is one bit wider than the address so it can hold
    // MAX_LINE, which marks a full line.
    localparam logic [ADDR_W:0] MAX_COL = (ADDR_W + 1)'(MAX_LINE);
    localparam logic [ADDR_W:0] COL_ONE = (ADDR_W + 1)'(1);

    logic [ADDR_W:0]   col_q;
    logic [ADDR_W:0]   line_len;
    logic              len_valid;
    logic              in_line;
    logic              sel;
    logic              sel_q;
    logic [DATA_W-1:0] bot_q;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] top_rd;
    logic [DATA_W-1:0] mid_rd;

    logic              accept;
    logic              new_line;
    logic              overflow;
    logic              len_err;
    logic              sel_eff;
    logic [ADDR_W:0]   col_eff;
    logic [1:0]        lf_now;

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned (no latch).
    always_comb begin
        accept   = 1'b0;
        new_line = 1'b0;
        overflow = 1'b0;
        len_err  = 1'b0;
        if (pix_valid && !flush) begin
            if (line_start) begin
                accept   = 1'b1;
                new_line = in_line;
                len_err  = in_line && len_valid && (col_q != line_len);
            end else if (in_line) begin
                accept   = (col_q != MAX_COL);
                overflow = (col_q == MAX_COL);
            end
        end
        // Bank swap and fill count take effect for the line_start pixel itself.
        sel_eff = new_line ? ~sel : sel;
        col_eff = (pix_valid && line_start) ? '0 : col_q;
        lf_now  = new_line ? fill_inc(lines_filled) : lines_filled;
    end

    // Bank A is written when sel_eff=1 (it is mem[~sel]), bank B when 0.
    dut_line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_LINE), .ADDR_W(ADDR_W)) u_ram_a (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .we    (sel_eff),
        .addr  (col_eff[ADDR_W-1:0]),
        .wdata (pix_data),
        .rdata (rd_a)
    );

    dut_line_ram #(.DATA_W(DATA_W), .DEPTH(MAX_LINE), .ADDR_W(ADDR_W)) u_ram_b (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .we    (~sel_eff),
        .addr  (col_eff[ADDR_W-1:0]),
        .wdata (pix_data),
        .rdata (rd_b)
    );

    assign top_rd = sel_q ? rd_a : rd_b;
    assign mid_rd = sel_q ? rd_b : rd_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            line_len     <= '0;
            len_valid    <= 1'b0;
            in_line      <= 1'b0;
            sel          <= 1'b0;
            lines_filled <= 2'd0;
            err          <= 1'b0;
        end else begin
            if (flush) begin
                lines_filled <= 2'd0;
                in_line      <= 1'b0;
                len_valid    <= 1'b0;
            end else if (accept) begin
                in_line      <= 1'b1;
                col_q        <= col_eff + COL_ONE;
                sel          <= sel_eff;
                lines_filled <= lf_now;
                if (new_line && !len_valid) begin
                    line_len  <= col_q;
                    len_valid <= 1'b1;
                end
            end
            if (overflow || len_err) begin
                err <= 1'b1;
            end
        end
    end

`ifdef DUT_LINE_BUFFER_EDGE_REPLICATE_EN
    logic [1:0] rep_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            bot_q     <= '0;
            sel_q     <= 1'b0;
            rep_q     <= 2'd0;
        end else begin
            win_valid <= accept;
            if (accept) begin
                win_col <= col_eff[ADDR_W-1:0];
                bot_q   <= pix_data;
                sel_q   <= sel_eff;
                rep_q   <= lf_now;
            end
        end
    end

    // Rows not yet stored are replaced by the nearest row that is.
    always_comb begin
        win_bot = bot_q;
        win_mid = (rep_q == 2'd0) ? bot_q : mid_rd;
        win_top = (rep_q == 2'd2) ? top_rd : win_mid;
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_col   <= '0;
            bot_q     <= '0;
            sel_q     <= 1'b0;
        end else begin
            win_valid <= accept && (lf_now == 2'd2);
            if (accept) begin
                win_col <= col_eff[ADDR_W-1:0];
                bot_q   <= pix_data;
                sel_q   <= sel_eff;
            end
        end
    end

    always_comb begin
        win_top = top_rd;
        win_mid = mid_rd;
        win_bot = bot_q;
    end
`endif

endmodule

// File: tb/tb_dut_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_dut_line_buffer
// Directed testbench for dut_line_buffer with a queue-based scoreboard:
// stimulus pushes the expected column, a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_dut_line_buffer;
    import dut_image_pkg::*;

`ifdef DUT_LINE_BUFFER_EDGE_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    typedef struct {
        int       due;
        pixel_t   top;
        pixel_t   mid;
        pixel_t   bot;
        win_col_t col;
    } exp_t;

    logic     clk = 1'b0;
    logic     rst;
    logic     flush;
    logic     line_start;
    logic     pix_valid;
    pixel_t   pix_data;
    pixel_t   win_top;
    pixel_t   win_mid;
    pixel_t   win_bot;
    logic     win_valid;
    win_col_t win_col;
    logic [1:0] lines_filled;
    logic     err;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    dut_line_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .line_start   (line_start),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .win_top      (win_top),
        .win_mid      (win_mid),
        .win_bot      (win_bot),
        .win_valid    (win_valid),
        .win_col      (win_col),
        .lines_filled (lines_filled),
        .err          (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented column must match the head of the queue on
    // its due cycle; a due entry with no win_valid is a missing output.
    always @(negedge clk) begin
        exp_t e;
        if (win_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_win_valid", win_valid, 0);
            end else begin
                e = q.pop_front();
                check("win_cycle", cyc, e.due);
                check("win_top", win_top, e.top);
                check("win_mid", win_mid, e.mid);
                check("win_bot", win_bot, e.bot);
                check("win_col", win_col, e.col);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            check("missing_win_valid", win_valid, 1);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input logic ls, input pixel_t d, input logic ev,
                       input pixel_t et, input pixel_t em, input win_col_t ec);
        if (ev) q.push_back('{due: cyc + 1, top: et, mid: em, bot: d, col: ec});
        pix_valid  = 1'b1;
        line_start = ls;
        pix_data   = d;
        idle(1);
        pix_valid  = 1'b0;
        line_start = 1'b0;
        pix_data   = '0;
    endtask

    // Line of n back-to-back pixels base+i; expected top/mid are tb+i / mb+i.
    task automatic line(input int n, input pixel_t base, input logic ev,
                        input pixel_t tb, input pixel_t mb);
        for (int i = 0; i < n; i++) begin
            pix(i == 0, base + pixel_t'(i), ev, tb + pixel_t'(i), mb + pixel_t'(i),
                win_col_t'(i));
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; line_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
        idle(3);
        check("rst_win_top", win_top, 0);
        check("rst_win_mid", win_mid, 0);
        check("rst_win_bot", win_bot, 0);
        check("rst_win_valid", win_valid, 0);
        check("rst_win_col", win_col, 0);
        check("rst_lines_filled", lines_filled, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        idle(1);

        // Fill: lines 1 and 2 give output only with replication.
        line(4, 8'h10, REP, 8'h10, 8'h10);
        check("fill_lf_line1", lines_filled, 0);
        line(4, 8'h20, REP, 8'h10, 8'h10);
        check("fill_lf_line2", lines_filled, 1);
        line(4, 8'h30, 1'b1, 8'h10, 8'h20);
        check("fill_lf_line3", lines_filled, 2);

        // Rotation.
        line(4, 8'h40, 1'b1, 8'h20, 8'h30);
        check("rot_lf", lines_filled, 2);
        check("rot_err", err, 0);

        // Gapped input: one pixel every third cycle.
        for (int i = 0; i < 4; i++) begin
            pix(i == 0, 8'h50 + pixel_t'(i), 1'b1, 8'h30 + pixel_t'(i),
                8'h40 + pixel_t'(i), win_col_t'(i));
            idle(2);
        end
        check("gap_err", err, 0);

        // Length mismatch: a 3-pixel line after 4-pixel lines.
        line(3, 8'h60, 1'b1, 8'h40, 8'h50);
        check("len_err_before", err, 0);
        pix(1'b1, 8'h70, 1'b1, 8'h50, 8'h60, 0);
        check("len_err_set", err, 1);
        pix(1'b0, 8'h71, 1'b1, 8'h51, 8'h61, 1);
        pix(1'b0, 8'h72, 1'b1, 8'h52, 8'h62, 2);

        // Flush mid-line with a simultaneous pixel, which is dropped.
        flush = 1'b1; pix_valid = 1'b1; pix_data = 8'h99;
        idle(1);
        flush = 1'b0; pix_valid = 1'b0; pix_data = '0;
        check("flush_win_valid", win_valid, 0);
        check("flush_lf", lines_filled, 0);
        check("flush_err_kept", err, 1);
        line(2, 8'h55, REP, 8'h55, 8'h55);
        line(2, 8'h57, REP, 8'h55, 8'h55);
        check("flush_lf_b", lines_filled, 1);
        pix(1'b1, 8'h59, 1'b1, 8'h55, 8'h57, 0);
        check("flush_lf_c", lines_filled, 2);

        // Reset mid-line.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("mid_rst_win_valid", win_valid, 0);
        check("mid_rst_win_top", win_top, 0);
        check("mid_rst_win_mid", win_mid, 0);
        check("mid_rst_win_bot", win_bot, 0);
        check("mid_rst_win_col", win_col, 0);
        check("mid_rst_lf", lines_filled, 0);
        check("mid_rst_err", err, 0);

        // Overflow: 66 pixels after one line_start.
        for (int i = 0; i < 66; i++) begin
            pix(i == 0, pixel_t'(i), REP && (i < 64), pixel_t'(i), pixel_t'(i),
                win_col_t'(i));
            if (i == 63) check("ovf_err_before", err, 0);
            if (i == 64) check("ovf_err_set", err, 1);
            if (i >= 64) check("ovf_dropped", win_valid, 0);
        end
        check("ovf_lf", lines_filled, 0);

        idle(3);
        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
